// File: rtl/reg_bank_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_writer_pkg
// Brief    : Shared constants and clear-FSM encoding for the register bank.
// Revision : 1.0
// ============================================================================
package reg_bank_writer_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 0;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_CLEAR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/reg_bank_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_writer_if
// Brief    : Write handshake, clear control and flat register bus.
// Revision : 1.0
// ============================================================================
interface reg_bank_writer_if #(
  parameter int DATA_W   = reg_bank_writer_pkg::DATA_W,
  parameter int ADDR_W   = reg_bank_writer_pkg::ADDR_W,
  parameter int NUM_REGS = reg_bank_writer_pkg::NUM_REGS
);

  logic                       WR_VALID;
  logic                       WR_READY;
  logic [ADDR_W-1:0]          WR_ADDR;
  logic [DATA_W-1:0]          WR_DATA;
  logic [DATA_W/8-1:0]        WR_BE;
  logic                       CLR_REQ;
  logic                       CLR_BUSY;
  logic [NUM_REGS*DATA_W-1:0] Q;

  modport master (
    output WR_VALID, WR_ADDR, WR_DATA, WR_BE, CLR_REQ,
    input  WR_READY, CLR_BUSY, Q
  );

  modport slave (
    input  WR_VALID, WR_ADDR, WR_DATA, WR_BE, CLR_REQ,
    output WR_READY, CLR_BUSY, Q
  );

endinterface
`default_nettype wire

// File: rtl/reg_bank_writer_decoder_5x32.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_writer_decoder_5x32
// Brief    : Enabled 5-to-32 one-hot decoder built from gate primitives.
// Revision : 1.0
// ============================================================================
module reg_bank_writer_decoder_5x32
  import reg_bank_writer_pkg::*;
(
  input  wire                i_en,
  input  wire [ADDR_W-1:0]   i_addr,
  output wire [NUM_REGS-1:0] o_onehot
);

  wire [ADDR_W-1:0] w_addr_n;

  for (genvar b = 0; b < ADDR_W; b++) begin : g_inv
    not u_inv (w_addr_n[b], i_addr[b]);
  end

  // Each row ANDs the enable with the true/complement literal of every address bit.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_row
    wire [ADDR_W-1:0] w_lit;
    for (genvar b = 0; b < ADDR_W; b++) begin : g_lit
      assign w_lit[b] = (((i >> b) & 1) != 0) ? i_addr[b] : w_addr_n[b];
    end
    and u_and (o_onehot[i], i_en, w_lit[0], w_lit[1], w_lit[2], w_lit[3], w_lit[4]);
  end

endmodule
`default_nettype wire

// File: rtl/reg_bank_writer.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_writer
// Brief    : Register bank write side with byte enables and sequenced clear.
// Revision : 1.0
// ============================================================================
module reg_bank_writer #(
  parameter int DATA_W   = reg_bank_writer_pkg::DATA_W,
  parameter int ADDR_W   = reg_bank_writer_pkg::ADDR_W,
  parameter int NUM_REGS = 2**ADDR_W,
  parameter bit R0_ZERO  = 1'b1
) (
  input wire logic         CLK,
  input wire logic         RST,
  reg_bank_writer_if.slave bus
);
  import reg_bank_writer_pkg::*;

  localparam int NB = DATA_W / 8;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_W-1:0]     r_idx;
  logic                  r_live;
  logic                  w_ready;
  logic                  w_busy;
  logic                  w_accept;
  logic                  w_dec_en;
  logic [ADDR_W-1:0]     w_dec_addr;
  wire  [NUM_REGS-1:0]   w_row_en;

  // r_live holds WR_READY low until the first edge after reset release.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      r_idx   <= (r_state == ST_CLEAR) ? r_idx + ADDR_W'(1) : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.CLR_REQ) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (r_idx == ADDR_W'(NUM_REGS - 1)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      ST_IDLE:  w_ready = r_live;
      ST_CLEAR: w_busy  = 1'b1;
      default:  ;
    endcase
  end

  assign bus.WR_READY = w_ready;
  assign bus.CLR_BUSY = w_busy;
  assign w_accept     = bus.WR_VALID & w_ready;

  // The sweep borrows the write decoder by steering its index onto the address.
  assign w_dec_addr = w_busy ? r_idx : bus.WR_ADDR;
  assign w_dec_en   = w_busy | w_accept;

  reg_bank_writer_decoder_5x32 u_dec (
    .i_en     (w_dec_en),
    .i_addr   (w_dec_addr),
    .o_onehot (w_row_en)
  );

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (R0_ZERO && (i == ZERO_REG)) begin : g_zero
      wire w_unused_row = w_row_en[i];
      assign bus.Q[i*DATA_W +: DATA_W] = '0;
    end else begin : g_store
      logic [DATA_W-1:0] r_val;
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          r_val <= '0;
        end else if (w_row_en[i]) begin
          if (w_busy) begin
            r_val <= '0;
          end else begin
            for (int k = 0; k < NB; k++) begin
              if (bus.WR_BE[k]) r_val[8*k +: 8] <= bus.WR_DATA[8*k +: 8];
            end
          end
        end
      end
      assign bus.Q[i*DATA_W +: DATA_W] = r_val;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_writer
// Brief    : Scoreboard bench for reg_bank_writer writes, byte enables, clear.
// Revision : 1.0
// ============================================================================
module tb_reg_bank_writer;

  typedef struct {
    string       name;
    int          idx;
    logic [31:0] exp_val;
    bit          is_ctrl;
    bit          exp_ready;
    bit          exp_busy;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_bank_writer_if ifc ();

  reg_bank_writer #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NUM_REGS (32),
    .R0_ZERO  (1'b1)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (ifc)
  );

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_reg(input string nm, input int idx, input logic [31:0] v);
    exp_t e;
    e.name = nm; e.idx = idx; e.exp_val = v;
    e.is_ctrl = 1'b0; e.exp_ready = 1'b0; e.exp_busy = 1'b0;
    sb.push_back(e);
  endtask

  task automatic exp_ctrl(input string nm, input bit r, input bit b);
    exp_t e;
    e.name = nm; e.idx = -1; e.exp_val = '0;
    e.is_ctrl = 1'b1; e.exp_ready = r; e.exp_busy = b;
    sb.push_back(e);
  endtask

  task automatic exp_all(input string nm);
    for (int i = 0; i < 32; i++) exp_reg(nm, i, model[i]);
  endtask

  task automatic do_write(input string nm, input logic [4:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    bit acc;
    int budget;
    ifc.WR_VALID = 1'b1;
    ifc.WR_ADDR  = a;
    ifc.WR_DATA  = d;
    ifc.WR_BE    = be;
    exp_reg({nm, "_nobypass"}, int'(a), model[a]);
    budget = 0;
    do begin
      acc = ifc.WR_READY;
      tick();
      budget++;
    end while (!acc && budget < 100);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: ready stayed 0 for %0d cycles, required 1", nm, budget);
    end
    ifc.WR_VALID = 1'b0;
  endtask

  // Monitor: everything queued since the last edge is compared at the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      checks++;
      if (e.is_ctrl) begin
        if (ifc.WR_READY !== e.exp_ready || ifc.CLR_BUSY !== e.exp_busy) begin
          errors++;
          $display("FAIL %s: ready/busy actual %b/%b required %b/%b",
                   e.name, ifc.WR_READY, ifc.CLR_BUSY, e.exp_ready, e.exp_busy);
        end
      end else begin
        act = ifc.Q[e.idx*32 +: 32];
        if (act !== e.exp_val) begin
          errors++;
          $display("FAIL %s: reg %0d actual %h required %h", e.name, e.idx, act, e.exp_val);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc.WR_VALID = 1'b0;
    ifc.WR_ADDR  = '0;
    ifc.WR_DATA  = '0;
    ifc.WR_BE    = '0;
    ifc.CLR_REQ  = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    tick();
    tick();
    exp_ctrl("reset_ctrl", 1'b0, 1'b0);
    exp_all("reset_q");
    rst_n = 1'b1;
    tick();
    exp_ctrl("ready_after_release", 1'b1, 1'b0);

    do_write("full", 5'd7, 32'hDEADBEEF, 4'hF);
    model[7] = 32'hDEADBEEF;
    exp_all("full_write");

    do_write("be", 5'd7, 32'h11223344, 4'b0101);
    model[7] = 32'hDE22BE44;
    exp_reg("be_write", 7, 32'hDE22BE44);

    do_write("be_zero", 5'd7, 32'hFFFFFFFF, 4'b0000);
    exp_reg("be_zero_hold", 7, 32'hDE22BE44);
    exp_ctrl("be_zero_ctrl", 1'b1, 1'b0);

    do_write("r0", 5'd0, 32'hFFFFFFFF, 4'hF);
    exp_reg("r0_protect", 0, 32'h0);

    for (int i = 1; i < 32; i++) begin
      do_write("fill", 5'(i), 32'(i), 4'hF);
      model[i] = 32'(i);
    end
    exp_all("fill");

    // Clear sweep with a write to reg 5 held pending throughout.
    ifc.CLR_REQ = 1'b1;
    exp_ctrl("sweep_pre", 1'b1, 1'b0);
    tick();
    ifc.CLR_REQ  = 1'b0;
    ifc.WR_VALID = 1'b1;
    ifc.WR_ADDR  = 5'd5;
    ifc.WR_DATA  = 32'h55AA55AA;
    ifc.WR_BE    = 4'hF;
    exp_ctrl("sweep_busy", 1'b0, 1'b1);
    for (int c = 1; c < 32; c++) begin
      tick();
      exp_ctrl("sweep_busy", 1'b0, 1'b1);
      if (c == 3) begin
        exp_reg("sweep_order_lo", 2, 32'h0);
        exp_reg("sweep_order_hi", 3, 32'h3);
      end
      if (c == 31) exp_reg("sweep_held_r5", 5, 32'h0);
    end
    tick();
    for (int i = 0; i < 32; i++) model[i] = '0;
    exp_ctrl("sweep_done", 1'b1, 1'b0);
    exp_all("sweep_clear");
    tick();
    ifc.WR_VALID = 1'b0;
    model[5] = 32'h55AA55AA;
    exp_reg("held_write", 5, 32'h55AA55AA);

    // Clear request coinciding with an accepted write to reg 31.
    ifc.CLR_REQ  = 1'b1;
    ifc.WR_VALID = 1'b1;
    ifc.WR_ADDR  = 5'd31;
    ifc.WR_DATA  = 32'hA5A5A5A5;
    ifc.WR_BE    = 4'hF;
    exp_ctrl("coll_pre", 1'b1, 1'b0);
    tick();
    ifc.CLR_REQ  = 1'b0;
    ifc.WR_VALID = 1'b0;
    exp_reg("coll_written", 31, 32'hA5A5A5A5);
    exp_ctrl("coll_busy", 1'b0, 1'b1);
    for (int c = 1; c < 32; c++) begin
      tick();
      if (c == 31) exp_reg("coll_before_last", 31, 32'hA5A5A5A5);
    end
    tick();
    model[5] = '0;
    exp_reg("coll_cleared", 31, 32'h0);
    exp_reg("coll_r5_cleared", 5, 32'h0);
    exp_ctrl("coll_idle", 1'b1, 1'b0);

    // Reset during the tenth sweep cycle.
    do_write("pre_abort", 5'd20, 32'hCAFEF00D, 4'hF);
    model[20] = 32'hCAFEF00D;
    ifc.CLR_REQ = 1'b1;
    tick();
    ifc.CLR_REQ = 1'b0;
    for (int c = 1; c < 10; c++) begin
      tick();
      if (c == 8) exp_reg("abort_pre", 20, 32'hCAFEF00D);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    exp_ctrl("abort_ctrl", 1'b0, 1'b0);
    exp_all("abort_q");
    tick();
    tick();
    rst_n = 1'b1;
    exp_ctrl("abort_release", 1'b0, 1'b0);
    tick();
    exp_ctrl("abort_idle", 1'b1, 1'b0);

    do_write("post_reset", 5'd2, 32'h0BADCAFE, 4'b1100);
    model[2] = 32'h0BAD0000;
    exp_reg("post_reset", 2, 32'h0BAD0000);
    exp_reg("post_reset_r20", 20, 32'h0);

    tick();
    tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
